tx_symbol_framer: RTL and testbench

TX_SYMBOL_FRAMER -- requirements
Module: tx_symbol_framer

---
 rtl/pcie_sym_pkg.sv | 47 ++++
 rtl/lane_sym_mux.sv | 56 +++++
 rtl/tx_symbol_framer.sv | 175 +++++++++++++++++
 tb/tb_tx_symbol_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_sym_pkg.sv
// ============================================================================
// pcie_sym_pkg : shared K codes, framer states and lane select encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pcie_sym_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  localparam int unsigned OS_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_END   = 3'd3,
    ST_SKPOS = 3'd4,
    ST_EIOS  = 3'd5,
    ST_EIDLE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SEL_DATA  = 2'd0,
    SEL_KCODE = 2'd1,
    SEL_ZERO  = 2'd2
  } lane_sel_t;

  // Ordered sets open with COM; the remaining symbols are SKP or IDL.
  function automatic logic [7:0] os_symbol(input logic is_skp, input logic [1:0] idx);
    if (idx == 2'd0) begin
      return K_COM;
    end
    return is_skp ? K_SKP : K_IDL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_sym_mux.sv
// ============================================================================
// lane_sym_mux : per-lane registered select between payload byte and K code
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_sym_mux
  import pcie_sym_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  lane_sel_t   sel_i,
  input  logic [7:0]  data_i,
  input  logic [7:0]  kcode_i,
  output logic [7:0]  sym_o,
  output logic        k_o
);

  logic [7:0] sym_d, sym_q;
  logic       k_d, k_q;

  always_comb begin
    sym_d = kcode_i;
    k_d   = 1'b1;
    case (sel_i)
      SEL_DATA: begin
        sym_d = data_i;
        k_d   = 1'b0;
      end
      SEL_ZERO: begin
        sym_d = 8'h00;
        k_d   = 1'b0;
      end
      default: begin
        sym_d = kcode_i;
        k_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q <= K_IDL;
      k_q   <= 1'b1;
    end else begin
      sym_q <= sym_d;
      k_q   <= k_d;
    end
  end

  assign sym_o = sym_q;
  assign k_o   = k_q;

endmodule

`default_nettype wire

// File: rtl/tx_symbol_framer.sv
// ============================================================================
// tx_symbol_framer : frames TLP/DLLP beats into lane symbols, inserts SKP/EIOS
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_symbol_framer
  import pcie_sym_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic                 pkt_type,
  input  logic [8*LANES-1:0]   pkt_data,
  input  logic                 pkt_last,
  input  logic                 eidle_req,
  output logic [8*LANES-1:0]   lane_data,
  output logic [LANES-1:0]     lane_k,
  output logic                 in_eidle
);

  localparam int              CNT_W    = 12;
  localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [1:0]      OS_LAST  = 2'(OS_LEN - 1);

  state_t           state_q, state_d;
  logic             type_q, type_d;
  logic [1:0]       os_idx_q, os_idx_d;
  logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
  logic             skp_pend_q, skp_pend_d;
  logic             pkt_ready_q, in_eidle_q;
  lane_sel_t        sel_d;
  logic [7:0]       k0_d, kn_d;
  logic             xfer;

  // pkt_ready_q always mirrors "state is DATA", so this is the handshake.
  assign xfer = pkt_valid && pkt_ready_q;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    os_idx_d = os_idx_q;
    sel_d    = SEL_KCODE;
    k0_d     = K_IDL;
    kn_d     = K_IDL;
    unique case (state_q)
      ST_IDLE: begin
        if (skp_pend_q) begin
          state_d  = ST_SKPOS;
          os_idx_d = 2'd0;
        end else if (eidle_req) begin
          state_d  = ST_EIOS;
          os_idx_d = 2'd0;
        end else if (pkt_valid) begin
          state_d = ST_START;
          type_d  = pkt_type;
        end
      end
      ST_START: begin
        k0_d    = type_q ? K_SDP : K_STP;
        kn_d    = K_PAD;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          sel_d = SEL_DATA;
          if (pkt_last) begin
            state_d = ST_END;
          end
        end else begin
          k0_d    = K_EDB;
          kn_d    = K_PAD;
          state_d = ST_IDLE;
        end
      end
      ST_END: begin
        k0_d    = K_END;
        kn_d    = K_PAD;
        state_d = ST_IDLE;
      end
      ST_SKPOS: begin
        k0_d     = os_symbol(1'b1, os_idx_q);
        kn_d     = k0_d;
        os_idx_d = os_idx_q + 2'd1;
        if (os_idx_q == OS_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_EIOS: begin
        k0_d     = os_symbol(1'b0, os_idx_q);
        kn_d     = k0_d;
        os_idx_d = os_idx_q + 2'd1;
        if (os_idx_q == OS_LAST) begin
          state_d = ST_EIDLE;
        end
      end
      ST_EIDLE: begin
        sel_d = SEL_ZERO;
        if (!eidle_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SKP scheduling: free-running except while sending SKPOS or sitting in EIDLE.
  always_comb begin
    skp_cnt_d  = skp_cnt_q;
    skp_pend_d = skp_pend_q;
    if (state_q == ST_SKPOS) begin
      if (os_idx_q == OS_LAST) begin
        skp_cnt_d  = '0;
        skp_pend_d = 1'b0;
      end
    end else if ((state_q != ST_EIDLE) && !skp_pend_q) begin
      if (skp_cnt_q == SKP_LAST) begin
        skp_pend_d = 1'b1;
      end else begin
        skp_cnt_d = skp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      type_q      <= 1'b0;
      os_idx_q    <= 2'd0;
      skp_cnt_q   <= '0;
      skp_pend_q  <= 1'b0;
      pkt_ready_q <= 1'b0;
      in_eidle_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      os_idx_q    <= os_idx_d;
      skp_cnt_q   <= skp_cnt_d;
      skp_pend_q  <= skp_pend_d;
      pkt_ready_q <= (state_d == ST_DATA);
      in_eidle_q  <= (state_d == ST_EIDLE);
    end
  end

  assign pkt_ready = pkt_ready_q;
  assign in_eidle  = in_eidle_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] kcode;
    if (g == 0) begin : g_lead
      assign kcode = k0_d;
    end else begin : g_tail
      assign kcode = kn_d;
    end

    lane_sym_mux u_mux (
      .clk     (clk),
      .reset   (reset),
      .sel_i   (sel_d),
      .data_i  (pkt_data[8*g +: 8]),
      .kcode_i (kcode),
      .sym_o   (lane_data[8*g +: 8]),
      .k_o     (lane_k[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_symbol_framer.sv
// ============================================================================
// tb_tx_symbol_framer : directed scoreboard bench for tx_symbol_framer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tx_symbol_framer;

  localparam int LANES        = 4;
  localparam int SKP_INTERVAL = 16;

  localparam logic [31:0] IDL4  = 32'h7C7C7C7C;
  localparam logic [31:0] COM4  = 32'hBCBCBCBC;
  localparam logic [31:0] SKP4  = 32'h1C1C1C1C;
  localparam logic [31:0] STP_F = 32'hF7F7F7FB;
  localparam logic [31:0] SDP_F = 32'hF7F7F75C;
  localparam logic [31:0] END_F = 32'hF7F7F7FD;
  localparam logic [31:0] EDB_F = 32'hF7F7F7FE;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        r;
    logic        e;
    logic [7:0]  tst;
    logic [7:0]  cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cur_test = 0;
  int   cur_cyc  = 0;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic              pkt_type  = 1'b0;
  logic [8*LANES-1:0] pkt_data = '0;
  logic              pkt_last  = 1'b0;
  logic              eidle_req = 1'b0;
  logic [8*LANES-1:0] lane_data;
  logic [LANES-1:0]  lane_k;
  logic              in_eidle;

  always #5 clk = ~clk;

  tx_symbol_framer #(
    .LANES        (LANES),
    .SKP_INTERVAL (SKP_INTERVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_type  (pkt_type),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .eidle_req (eidle_req),
    .lane_data (lane_data),
    .lane_k    (lane_k),
    .in_eidle  (in_eidle)
  );

  // One expected word per clock, in order, starting with the reset edge.
  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic r, input logic e);
    exp_t x;
    x.d   = d;
    x.k   = k;
    x.r   = r;
    x.e   = e;
    x.tst = 8'(cur_test);
    x.cyc = 8'(cur_cyc);
    cur_cyc++;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      n_cmp++;
      if (lane_data !== mon_x.d || lane_k !== mon_x.k ||
          pkt_ready !== mon_x.r || in_eidle !== mon_x.e) begin
        n_bad++;
        $display("FAIL t%0d.E%0d got data=%h k=%b rdy=%b eidle=%b want data=%h k=%b rdy=%b eidle=%b",
                 mon_x.tst, mon_x.cyc, lane_data, lane_k, pkt_ready, in_eidle,
                 mon_x.d, mon_x.k, mon_x.r, mon_x.e);
      end
    end
  end

  task automatic begin_test(input int id);
    @(negedge clk);
    reset     = 1'b1;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    pkt_type  = 1'b0;
    eidle_req = 1'b0;
    pkt_data  = '0;
    cur_test  = id;
    cur_cyc   = 0;
    push(IDL4, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout t%0d left=%0d want=0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] beat(input int j);
    return 32'h40302010 + 32'(j) * 32'h01010101;
  endfunction

  initial begin
    // Test 1: reset state then a 3-beat TLP
    begin_test(1);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(STP_F, 4'hF, 1'b1, 1'b0);
    push(32'hA1B2C3D4, 4'h0, 1'b1, 1'b0);
    push(32'h55667788, 4'h0, 1'b1, 1'b0);
    push(32'hDEADBEEF, 4'h0, 1'b0, 1'b0);
    push(END_F, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 32'hA1B2C3D4; pkt_last = 1'b0;
    repeat (3) @(negedge clk);
    pkt_data = 32'h55667788;
    @(negedge clk);
    pkt_data = 32'hDEADBEEF; pkt_last = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    drain();

    // Test 2: DLLP with underrun on the second beat; type change after start is ignored
    begin_test(2);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(SDP_F, 4'hF, 1'b1, 1'b0);
    push(32'h0BADF00D, 4'h0, 1'b1, 1'b0);
    push(EDB_F, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; pkt_valid = 1'b1; pkt_type = 1'b1; pkt_data = 32'h0BADF00D;
    @(negedge clk);
    pkt_type = 1'b0;
    repeat (2) @(negedge clk);
    pkt_valid = 1'b0;
    drain();

    // Test 3: eidle_req beats pkt_valid; EIDLE holds the SKP counter; single-beat packet after
    begin_test(3);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(COM4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) push(32'h0, 4'h0, 1'b0, 1'b1);
    push(32'h0, 4'h0, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(STP_F, 4'hF, 1'b1, 1'b0);
    push(32'h13579BDF, 4'h0, 1'b0, 1'b0);
    push(END_F, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; eidle_req = 1'b1; pkt_valid = 1'b1; pkt_type = 1'b0;
    pkt_data = 32'h13579BDF; pkt_last = 1'b1;
    repeat (15) @(negedge clk);
    eidle_req = 1'b0;
    repeat (4) @(negedge clk);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    drain();

    // Test 4: reset in DATA aborts without END
    begin_test(4);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(STP_F, 4'hF, 1'b1, 1'b0);
    push(32'hCAFEF00D, 4'h0, 1'b1, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    reset = 1'b1; pkt_data = 32'h12345678; pkt_last = 1'b1;
    @(negedge clk);
    reset = 1'b0; pkt_valid = 1'b0; pkt_last = 1'b0;
    drain();

    // Test 5: SKP expiry inside a 16-beat packet is deferred until after END and IDLE
    begin_test(5);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(STP_F, 4'hF, 1'b1, 1'b0);
    for (int j = 0; j < 15; j++) push(beat(j), 4'h0, 1'b1, 1'b0);
    push(beat(15), 4'h0, 1'b0, 1'b0);
    push(END_F, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(COM4, 4'hF, 1'b0, 1'b0);
    push(SKP4, 4'hF, 1'b0, 1'b0);
    push(SKP4, 4'hF, 1'b0, 1'b0);
    push(SKP4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    push(IDL4, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; pkt_valid = 1'b1; pkt_type = 1'b0; pkt_data = beat(0); pkt_last = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      pkt_data = beat(j);
      pkt_last = (j == 15);
    end
    @(negedge clk);
    pkt_valid = 1'b0; pkt_last = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout compared=%0d want=finished", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
